// File: rtl/formula_vector_enumerator.sv
// Enumerates input vectors lo..hi and sends them to a formula evaluator over valid/ready.
// Counts results with o_1=0 and captures the first violating vector.
//
// state   | meaning
// IDLE    | no run active, waiting for start
// ISSUE   | vec_valid high, waiting for vec_ready
// WAIT    | one vector outstanding, waiting for res_valid
// DONE    | run finished or range error, done held high
module formula_vector_enumerator #(
    parameter int N_IN  = 25,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [N_IN-1:0]  lo,
    input  logic [N_IN-1:0]  hi,
    input  logic             stop_on_fail,
    output logic             vec_valid,
    input  logic             vec_ready,
    output logic [N_IN-1:0]  vec_data,
    input  logic             res_valid,
    input  logic             res_bit,
    output logic             busy,
    output logic             done,
    output logic             range_err,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             cex_valid,
    output logic [N_IN-1:0]  cex_vec
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic [N_IN-1:0]  r_cur;
    logic [N_IN-1:0]  r_hi;
    logic             r_stop;
    logic             r_vec_valid;
    logic             r_busy;
    logic             r_done;
    logic             r_range_err;
    logic [CNT_W-1:0] r_fail_cnt;
    logic             r_cex_valid;
    logic [N_IN-1:0]  r_cex_vec;

    logic             w_fail;
    logic             w_last;
    logic             w_cnt_max;

    assign w_fail    = ~res_bit;
    // Compare against hi before incrementing so hi = all-ones never wraps cur to 0.
    assign w_last    = (r_cur == r_hi) || (r_stop && w_fail);
    assign w_cnt_max = &r_fail_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cur       <= '0;
            r_hi        <= '0;
            r_stop      <= 1'b0;
            r_vec_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_range_err <= 1'b0;
            r_fail_cnt  <= '0;
            r_cex_valid <= 1'b0;
            r_cex_vec   <= '0;
        end else if (abort) begin
            // Result bookkeeping is kept so the harness can still read it after an abort.
            r_state     <= S_IDLE;
            r_vec_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_hi   <= hi;
                        r_stop <= stop_on_fail;
                        if (lo > hi) begin
                            r_state     <= S_DONE;
                            r_range_err <= 1'b1;
                            r_fail_cnt  <= '0;
                            r_done      <= 1'b1;
                        end else begin
                            r_state     <= S_ISSUE;
                            r_cur       <= lo;
                            r_fail_cnt  <= '0;
                            r_cex_valid <= 1'b0;
                            r_range_err <= 1'b0;
                            r_done      <= 1'b0;
                            r_vec_valid <= 1'b1;
                            r_busy      <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (vec_ready) begin
                        r_state     <= S_WAIT;
                        r_vec_valid <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (res_valid) begin
                        if (w_fail) begin
                            if (!w_cnt_max) begin
                                r_fail_cnt <= r_fail_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                            end
                            if (!r_cex_valid) begin
                                r_cex_vec   <= r_cur;
                                r_cex_valid <= 1'b1;
                            end
                        end
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state     <= S_ISSUE;
                            r_cur       <= r_cur + {{(N_IN-1){1'b0}}, 1'b1};
                            r_vec_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign vec_valid = r_vec_valid;
    assign vec_data  = r_cur;
    assign busy      = r_busy;
    assign done      = r_done;
    assign range_err = r_range_err;
    assign fail_cnt  = r_fail_cnt;
    assign cex_valid = r_cex_valid;
    assign cex_vec   = r_cex_vec;

endmodule

// File: doc/formula_vector_enumerator.md
Name: formula_vector_enumerator

Overview:
- Sequential stimulus engine that drives the "other end" of our single-output formula netlists (inputs v_1..v_N, output o_1).
- Enumerates input assignments over a programmed range and issues each one to a formula evaluator over a valid/ready handshake.
- Collects the o_1 result for each assignment, counts assignments with o_1=0 (violations), and captures the first violating vector.
- Sits between the benchmark harness/CSR block and a wrapped formula instance, which may be registered or pipelined.

Parameters:
- N_IN, 25, formula input count; vector width. Bit i drives v_(i+1).
- CNT_W, 32, width of the fail counter. Saturating.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches lo/hi/stop_on_fail; accepted only in IDLE or DONE
- abort  in  1  returns to IDLE from any state next cycle
- lo  in  N_IN  first vector (inclusive)
- hi  in  N_IN  last vector (inclusive)
- stop_on_fail  in  1  finish at first violation
- vec_valid  out  1  vec_data is valid
- vec_ready  in  1  evaluator accepts vec_data
- vec_data  out  N_IN  assignment to v_1..v_N
- res_valid  in  1  evaluator result strobe
- res_bit  in  1  o_1 for the last accepted vector
- busy  out  1  state is ISSUE or WAIT
- done  out  1  run finished; held until the next start or abort
- range_err  out  1  lo > hi at start
- fail_cnt  out  CNT_W  number of violations
- cex_valid  out  1  cex_vec holds the first violation
- cex_vec  out  N_IN  first violating vector

Behaviour:
- Reset values: all outputs 0; state IDLE; cur=0.
- The clock and reset are fixed: one clock, clk; reset rst_n is asynchronous and active-low.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE/DONE + start:
  - If lo > hi: go to DONE, set range_err=1, fail_cnt=0.
  - Otherwise: cur=lo; clear fail_cnt, cex_valid, range_err, done; go to ISSUE.
- ISSUE:
  - vec_valid=1 and vec_data=cur, both registered.
  - vec_data stays stable while vec_valid && !vec_ready.
  - On vec_valid && vec_ready: go to WAIT; vec_valid drops next cycle.
  - At most one vector is outstanding.
- WAIT:
  - Wait any number of cycles for res_valid.
  - On res_valid with res_bit=0: fail_cnt += 1, saturating at all-ones. If cex_valid=0, set cex_vec=cur and cex_valid=1.
  - After the result:
    - If cur==hi, or stop_on_fail && res_bit==0: go to DONE with done=1.
    - Otherwise: cur += 1 and go to ISSUE.
- Latency: minimum 2 cycles per vector (ISSUE handshake, then WAIT with res_valid in the following cycle). A result is never accepted in the handshake cycle itself.
- res_valid outside WAIT is ignored: no count, no state change.
- start while busy is ignored. start in DONE restarts the run.
- abort has priority over start and over res_valid in the same cycle:
  - Next cycle: IDLE, vec_valid=0, busy=0, done=0.
  - fail_cnt, cex_vec and cex_valid retain their values.
- Wrap-around: hi = all-ones terminates at cur==hi; cur never wraps to 0. Compare before incrementing.
- lo == hi: exactly one vector is issued.
- Asynchronous reset mid-run: immediate return to reset values. An in-flight evaluator result is dropped.
- busy = (state==ISSUE || state==WAIT), registered.

Test Plan:
- Use N_IN=4. Responder always ready, res_bit=0 only for vectors 5 and 9. Run lo=0, hi=15, stop_on_fail=0 → 16 handshakes, fail_cnt=2, cex_vec=5, cex_valid=1, done=1.
- Same responder, stop_on_fail=1 → last vec_data=5, 6 handshakes, fail_cnt=1, done=1.
- Hold vec_ready=0 for 3 cycles on each vector, and delay res_valid by 4 cycles. Run lo=3, hi=4 → vec_data stable while stalled, exactly 2 results counted. Stray res_valid pulses during ISSUE and DONE are ignored.
- lo=9, hi=2 → DONE on the next cycle with range_err=1, vec_valid never asserted, fail_cnt=0.
- lo=14, hi=15 with all-fail responder → fail_cnt=2, cex_vec=14, no wrap to 0. Then start with lo=15, hi=15 → single vector issued.
- Pulse abort during WAIT together with res_valid=1, res_bit=0 → IDLE next cycle, fail_cnt unchanged. Assert rst_n=0 mid-ISSUE → all outputs 0 asynchronously.
